// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// Each confirmed press becomes a one-cycle enter/start strobe or a held digit/op update.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] digit,
    output logic [2:0] op,
    output logic       enter,
    output logic       start,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    localparam logic [3:0] CODE_STAR = 4'd12;

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt, cnt_inc;
    logic [3:0]       cand, cand_nxt;
    logic [3:0]       row_p0, row_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col;
    logic [1:0]       acc_hits, hits_now;
    logic [3:0]       acc_code, code_now;
    logic [3:0]       low;
    logic [2:0]       slot_hits, tot_hits;
    logic             slot_end, frame_end;
    logic             one, none;
    logic             act;
    logic [4:0]       dec;

    function automatic logic [2:0] count_low(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // {valid, value} for the ten digit keys; everything else is not a digit
    function automatic logic [4:0] digit_of(input logic [3:0] code);
        case (code)
            4'd0:    return {1'b1, 4'd1};
            4'd1:    return {1'b1, 4'd2};
            4'd2:    return {1'b1, 4'd3};
            4'd4:    return {1'b1, 4'd4};
            4'd5:    return {1'b1, 4'd5};
            4'd6:    return {1'b1, 4'd6};
            4'd8:    return {1'b1, 4'd7};
            4'd9:    return {1'b1, 4'd8};
            4'd10:   return {1'b1, 4'd9};
            4'd13:   return {1'b1, 4'd0};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    assign col_out   = ~(4'b0001 << col);
    assign slot_end  = (div_cnt == SLOT_LAST);
    assign frame_end = slot_end && (col == 2'd3);

    // Rows are sampled late in the slot so the two sync flops have caught up
    // with the column that is currently driven.
    assign low       = ~row_p1;
    assign slot_hits = count_low(low);
    assign tot_hits  = {1'b0, acc_hits} + slot_hits;
    assign hits_now  = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
    assign code_now  = (acc_hits == 2'd0 && slot_hits == 3'd1) ? {low_row(low), col} : acc_code;
    assign one       = (hits_now == 2'd1);
    assign none      = (hits_now == 2'd0);
    assign cnt_inc   = cnt + 4'd1;
    assign dec       = digit_of(code_now);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_p0   <= 4'hF;
            row_p1   <= 4'hF;
            div_cnt  <= '0;
            col      <= '0;
            acc_hits <= '0;
            acc_code <= '0;
        end else begin
            row_p0 <= row_in;
            row_p1 <= row_p0;
            if (slot_end) begin
                div_cnt <= '0;
                col     <= col + 2'd1;
                if (frame_end) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= hits_now;
                    acc_code <= code_now;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        act       = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (one) begin
                        cand_nxt = code_now;
                        if (DEBOUNCE == 1) begin
                            act       = 1'b1;
                            state_nxt = HELD;
                            cnt_nxt   = 4'd0;
                        end else begin
                            state_nxt = CONFIRM;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                CONFIRM: begin
                    if (one && code_now == cand) begin
                        if (cnt_inc >= DEB) begin
                            act       = 1'b1;
                            state_nxt = HELD;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if (one) begin
                        cand_nxt = code_now;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                HELD: begin
                    // Any key activity keeps us here: no auto-repeat, no second key
                    if (none) begin
                        if (DEBOUNCE == 1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = 4'd0;
                        end else begin
                            state_nxt = RELEASE;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (none) begin
                        if (cnt_inc >= DEB) begin
                            state_nxt = IDLE;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = HELD;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit    <= '0;
            op       <= '0;
            enter    <= 1'b0;
            start    <= 1'b0;
            key_code <= '0;
        end else begin
            enter <= 1'b0;
            start <= 1'b0;
            if (act) begin
                key_code <= code_now;
                if (dec[4]) begin
                    digit <= dec[3:0];
                    enter <= 1'b1;
                end else if (code_now[1:0] == 2'd3) begin
                    op <= {1'b0, code_now[3:2]};
                end else if (code_now == CODE_STAR) begin
                    start <= 1'b1;
                end
            end
        end
    end

endmodule
